// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared widths, state encoding and pixel record for the VGA plot path
package vga_pkg;

  localparam int VGA_X_W     = 8;
  localparam int VGA_Y_W     = 7;
  localparam int VGA_COLOR_W = 15;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic [VGA_X_W-1:0]     x;
    logic [VGA_Y_W-1:0]     y;
    logic [VGA_COLOR_W-1:0] color;
  } pixel_t;

  function automatic pixel_t make_pixel(input logic [VGA_X_W-1:0] x,
                                        input logic [VGA_Y_W-1:0] y,
                                        input logic [VGA_COLOR_W-1:0] color);
    pixel_t p;
    p.x     = x;
    p.y     = y;
    p.color = color;
    return p;
  endfunction

endpackage

// File: rtl/vga_plot_sequencer_if.sv
// rtl/vga_plot_sequencer_if.sv - plot request, adapter write and status signals of the sequencer
interface vga_plot_sequencer_if #(
  parameter int DEPTH = 4
);
  import vga_pkg::*;

  logic                     vga_plot;
  logic [VGA_X_W-1:0]       vga_x;
  logic [VGA_Y_W-1:0]       vga_y;
  logic [VGA_COLOR_W-1:0]   vga_color;
  logic                     vga_resetn;
  logic                     plot_ready;

  logic                     out_plot;
  logic [VGA_X_W-1:0]       out_x;
  logic [VGA_Y_W-1:0]       out_y;
  logic [VGA_COLOR_W-1:0]   out_color;
  logic                     out_ready;

  logic                     clearing;
  logic                     overflow;
  logic                     range_err;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    input  vga_plot, vga_x, vga_y, vga_color, vga_resetn, out_ready,
    output plot_ready, out_plot, out_x, out_y, out_color,
    output clearing, overflow, range_err, level
  );

  modport slave (
    output vga_plot, vga_x, vga_y, vga_color, vga_resetn, out_ready,
    input  plot_ready, out_plot, out_x, out_y, out_color,
    input  clearing, overflow, range_err, level
  );

endinterface

// File: rtl/vga_plot_sequencer_fifo.sv
// rtl/vga_plot_sequencer_fifo.sv - pixel FIFO with synchronous flush; push into a full FIFO is accepted only alongside a pop
module plot_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push,
  input  pixel_t                 push_data,
  input  logic                   pop,
  output pixel_t                 pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  pixel_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (level == FULL_LEVEL);
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/vga_plot_sequencer.sv
// rtl/vga_plot_sequencer.sv - queues core plot requests, sweeps the screen clear, and drives adapter writes
module vga_plot_sequencer
  import vga_pkg::*;
#(
  parameter int                     DEPTH       = 4,
  parameter int unsigned            SCREEN_W    = 160,
  parameter int unsigned            SCREEN_H    = 120,
  parameter logic [VGA_COLOR_W-1:0] CLEAR_COLOR = 15'h0000
) (
  input  logic               clock,
  input  logic               resetn,
  vga_plot_sequencer_if.master bus
);

  localparam int LW = $clog2(DEPTH);
  localparam logic [LW:0]         FULL_LEVEL = DEPTH[LW:0];
  localparam logic [VGA_X_W-1:0]  LAST_X     = VGA_X_W'(SCREEN_W - 1);
  localparam logic [VGA_Y_W-1:0]  LAST_Y     = VGA_Y_W'(SCREEN_H - 1);

  state_t             state;
  logic               vga_prev;
  logic [VGA_X_W-1:0] cx;
  logic [VGA_Y_W-1:0] cy;

  logic   fall;
  logic   accept;
  logic   in_range;
  logic   fifo_push;
  logic   fifo_pop;
  logic   fifo_full;
  logic   fifo_empty;
  pixel_t head;
  pixel_t req;

  assign fall     = vga_prev && !bus.vga_resetn;
  assign accept   = bus.out_plot && bus.out_ready;
  assign in_range = (32'(bus.vga_x) < SCREEN_W) && (32'(bus.vga_y) < SCREEN_H);
  assign req      = make_pixel(bus.vga_x, bus.vga_y, bus.vga_color);

  // A clear request discards everything in flight, including a same-cycle enqueue.
  assign fifo_push = bus.vga_plot && in_range && !fall;
  assign fifo_pop  = (state == ST_RUN) && (!bus.out_plot || bus.out_ready) && !fifo_empty && !fall;

  assign bus.plot_ready = (bus.level < FULL_LEVEL);

  plot_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .flush     (fall),
    .push      (fifo_push),
    .push_data (req),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (bus.level)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= ST_CLEAR;
      vga_prev      <= 1'b1;
      cx            <= '0;
      cy            <= '0;
      bus.clearing  <= 1'b1;
      bus.out_plot  <= 1'b0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
      bus.out_color <= '0;
      bus.overflow  <= 1'b0;
      bus.range_err <= 1'b0;
    end else begin
      vga_prev <= bus.vga_resetn;
      if (bus.vga_plot && !fall && !in_range) begin
        bus.range_err <= 1'b1;
      end
      if (bus.vga_plot && !fall && in_range && fifo_full && !fifo_pop) begin
        bus.overflow <= 1'b1;
      end

      if (fall) begin
        state        <= ST_CLEAR;
        bus.clearing <= 1'b1;
        cx           <= '0;
        cy           <= '0;
        bus.out_plot <= 1'b0;
      end else begin
        case (state)
          ST_CLEAR: begin
            // cx/cy always name the beat currently presented to the adapter.
            if (!bus.out_plot) begin
              bus.out_plot  <= 1'b1;
              bus.out_x     <= cx;
              bus.out_y     <= cy;
              bus.out_color <= CLEAR_COLOR;
            end else if (accept) begin
              if (cx == LAST_X && cy == LAST_Y) begin
                state        <= ST_RUN;
                bus.clearing <= 1'b0;
                bus.out_plot <= 1'b0;
              end else if (cx == LAST_X) begin
                cx        <= '0;
                cy        <= cy + 1'b1;
                bus.out_x <= '0;
                bus.out_y <= cy + 1'b1;
              end else begin
                cx        <= cx + 1'b1;
                bus.out_x <= cx + 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (fifo_pop) begin
              bus.out_plot  <= 1'b1;
              bus.out_x     <= head.x;
              bus.out_y     <= head.y;
              bus.out_color <= head.color;
            end else if (accept) begin
              bus.out_plot <= 1'b0;
            end
          end
          default: state <= ST_CLEAR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_plot_sequencer.sv
// tb/tb_vga_plot_sequencer.sv - directed and randomized checks against a queue-based reference model
module tb_vga_plot_sequencer;
  import vga_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 160;
  localparam int H     = 120;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  vga_plot_sequencer_if #(.DEPTH(DEPTH)) bus ();

  vga_plot_sequencer #(
    .DEPTH(DEPTH), .SCREEN_W(W), .SCREEN_H(H), .CLEAR_COLOR(15'h0000)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending plots as a queue plus one presented beat.
  logic [29:0] fq[$];
  bit          m_clear, m_valid, m_ovf, m_rerr, m_prev;
  int          m_cx, m_cy;
  logic [29:0] m_pix;

  int          beats       = 0;
  int          clear_beats = 0;
  logic [29:0] last_beat   = '0;

  task automatic model_reset();
    fq.delete();
    m_clear = 1; m_valid = 0; m_ovf = 0; m_rerr = 0; m_prev = 1;
    m_cx = 0; m_cy = 0; m_pix = '0;
  endtask

  task automatic cycle(input bit plot, input int x, input int y, input logic [14:0] c,
                       input bit vr, input bit rdy);
    bit fall, pop_ok, push_ok;
    logic [29:0] req;
    bus.vga_plot = plot; bus.vga_x = 8'(x); bus.vga_y = 7'(y); bus.vga_color = c;
    bus.vga_resetn = vr; bus.out_ready = rdy;
    if (bus.out_plot && rdy) begin
      beats++;
      last_beat = {bus.out_x, bus.out_y, bus.out_color};
      if (bus.clearing) clear_beats++;
    end

    req     = {8'(x), 7'(y), c};
    fall    = m_prev && !vr;
    m_prev  = vr;
    pop_ok  = !m_clear && (!m_valid || rdy) && fq.size() > 0 && !fall;
    push_ok = 0;
    if (plot && !fall) begin
      if (x >= W || y >= H) m_rerr = 1;
      else if (fq.size() < DEPTH || pop_ok) push_ok = 1;
      else m_ovf = 1;
    end
    if (fall) begin
      fq.delete();
      m_clear = 1; m_cx = 0; m_cy = 0; m_valid = 0;
    end else if (m_clear) begin
      if (!m_valid) m_valid = 1;
      else if (rdy) begin
        if (m_cx == W-1 && m_cy == H-1) begin
          m_clear = 0; m_valid = 0;
        end else begin
          m_cx = m_cx + 1;
          if (m_cx == W) begin m_cx = 0; m_cy = m_cy + 1; end
        end
      end
      m_pix = {8'(m_cx), 7'(m_cy), 15'h0};
    end else if (!m_valid || rdy) begin
      if (pop_ok) begin m_pix = fq.pop_front(); m_valid = 1; end
      else m_valid = 0;
    end
    if (push_ok) fq.push_back(req);

    @(negedge clock);
    check("out_plot", bus.out_plot, m_valid);
    if (m_valid) check("out_pix", {bus.out_x, bus.out_y, bus.out_color}, m_pix);
    check("level", bus.level, fq.size());
    check("plot_ready", bus.plot_ready, fq.size() < DEPTH);
    check("clearing", bus.clearing, m_clear);
    check("overflow", bus.overflow, m_ovf);
    check("range_err", bus.range_err, m_rerr);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 15'h0, 1, rdy);
  endtask

  task automatic rand_plot(input bit rdy);
    cycle(1, $urandom_range(0, W-1), $urandom_range(0, H-1), 15'($urandom), 1, rdy);
  endtask

  task automatic run_sweep(input string tag);
    for (int i = 0; i < 20000 && bus.clearing; i++) idle(1, 1);
    check({tag, "_done"}, bus.clearing, 0);
    check({tag, "_beats"}, clear_beats, 19200);
    check({tag, "_last"}, last_beat, {8'd159, 7'd119, 15'h0});
  endtask

  initial begin
    int b0;
    bit found;
    bus.vga_plot = 0; bus.vga_x = 0; bus.vga_y = 0; bus.vga_color = 0;
    bus.vga_resetn = 1; bus.out_ready = 1;
    resetn = 0;
    @(negedge clock); @(negedge clock);
    check("rst_out_plot", bus.out_plot, 0);
    check("rst_level", bus.level, 0);
    check("rst_flags", {bus.overflow, bus.range_err}, 0);
    check("rst_clearing", bus.clearing, 1);
    check("rst_out_pix", {bus.out_x, bus.out_y, bus.out_color}, 0);
    model_reset();
    resetn = 1;

    // Power-on sweep.
    clear_beats = 0;
    run_sweep("sweep0");

    // Single plot latency.
    cycle(1, 10, 20, 15'h7C00, 1, 1);
    check("lat_k1", bus.out_plot, 0);
    idle(1, 1);
    check("lat_k2", {bus.out_plot, bus.out_x, bus.out_y, bus.out_color}, {1'b1, 8'd10, 7'd20, 15'h7C00});
    idle(1, 1);
    check("lat_one_beat", bus.out_plot, 0);

    // Out-of-range plots are dropped.
    b0 = beats;
    cycle(1, 160, 0, 15'h1234, 1, 1);
    cycle(1, 0, 120, 15'h4321, 1, 1);
    idle(3, 1);
    check("range_beats", beats - b0, 0);
    check("range_err_set", bus.range_err, 1);
    check("range_no_ovf", bus.overflow, 0);

    // Full FIFO with simultaneous accept and plot.
    for (int i = 0; i < 5; i++) rand_plot(0);
    check("full_level", bus.level, 4);
    check("full_ready", bus.plot_ready, 0);
    rand_plot(1);
    check("pushpop_level", bus.level, 4);
    check("pushpop_ovf", bus.overflow, 0);
    idle(8, 1);

    // Overflow on the sixth plot, then ordered drain.
    for (int i = 0; i < 5; i++) rand_plot(0);
    check("ovf_level", bus.level, 4);
    check("ovf_ready", bus.plot_ready, 0);
    rand_plot(0);
    check("ovf_set", bus.overflow, 1);
    b0 = beats;
    idle(10, 1);
    check("drain_beats", beats - b0, 5);

    // Mid-sweep restart with queued plots.
    cycle(0, 0, 0, 15'h0, 0, 1);
    cycle(0, 0, 0, 15'h0, 1, 1);
    rand_plot(1);
    rand_plot(1);
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (bus.out_plot && bus.out_x == 8'd37 && bus.out_y == 7'd5) found = 1;
      else idle(1, 1);
    end
    check("mid_found", found, 1);
    cycle(0, 0, 0, 15'h0, 0, 1);
    clear_beats = 0;
    cycle(0, 0, 0, 15'h0, 0, 1);
    cycle(0, 0, 0, 15'h0, 0, 1);
    run_sweep("sweep1");
    b0 = beats;
    idle(6, 1);
    check("flushed_beats", beats - b0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 169), $urandom_range(0, 125),
            15'($urandom), 1, $urandom_range(0, 9) < 7);
    end
    idle(10, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
